// File: rtl/sr_pkg.sv
// Shared definitions for the SR-latch write sequencer: FSM state encoding,
// default phase lengths and a small sizing helper.
package sr_pkg;

    // Sequencer states, 3-bit encoding fixed so the state can be read on a probe.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_SET    = 3'd2,
        ST_HOLD   = 3'd3,
        ST_VERIFY = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Default number of cycles is0 is held during the clear phase.
    localparam int DEF_CLR_CYCLES   = 1;
    // Default number of cycles s is held during the set phase.
    localparam int DEF_PULSE_CYCLES = 2;

    // Larger of two integers, used to size the shared phase counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable saturating down-counter. The sequencer reloads it on every state
// transition; tc is high while the count sits at zero, so a load value of
// K-1 makes the phase last exactly K cycles.
module phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    // Count register: reload has priority, otherwise count down and stop at zero.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its inputs from before the edge; blocking here would create
        // order-dependent simulation that need not match the synthesized logic.
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_tc = (r_count == '0);

endmodule

// File: rtl/sr_write_sequencer.sv
// Write sequencer for a bank of N SR-latch cells. Each write clears the bank
// through is0, pulses s on the bits that must be 1 (r on the others), lets
// the cells settle, then compares the readback against the captured word.
// Drive outputs are Moore-decoded from the state register, which makes the
// s/r exclusivity and the is0-vs-s exclusivity hold by construction.
module sr_write_sequencer
    import sr_pkg::*;
#(
    parameter int N            = 8,
    parameter int CLR_CYCLES   = DEF_CLR_CYCLES,
    parameter int PULSE_CYCLES = DEF_PULSE_CYCLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] data,
    input  logic [N-1:0] q_in,
    output logic [N-1:0] s_out,
    output logic [N-1:0] r_out,
    output logic         is0_out,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [N-1:0] err_mask
);

    // Counter wide enough for the longer phase, with one spare bit.
    localparam int CNT_W = $clog2(max_int(CLR_CYCLES, PULSE_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] CLR_LOAD   = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [N-1:0]     r_data_l;
    logic             r_error;
    logic [N-1:0]     r_err_mask;
    logic             w_accept;
    logic             w_tmr_load;
    logic [CNT_W-1:0] w_tmr_val;
    logic             w_tmr_tc;
    logic [N-1:0]     w_mismatch;

    assign w_accept   = (r_state == ST_IDLE) && start;
    assign w_mismatch = r_data_l ^ q_in;

    // Shared phase timer for the CLEAR and SET phases.
    phase_timer #(
        .W (CNT_W)
    ) u_phase_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_tc       (w_tmr_tc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic, timer reload and Moore drive decode.
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        w_next_state = r_state;
        w_tmr_load   = 1'b0;
        w_tmr_val    = '0;
        s_out        = '0;
        r_out        = '0;
        is0_out      = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next_state = ST_CLEAR;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = CLR_LOAD;
                end
            end
            ST_CLEAR: begin
                is0_out = 1'b1;
                if (w_tmr_tc) begin
                    w_next_state = ST_SET;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = PULSE_LOAD;
                end
            end
            ST_SET: begin
                s_out = r_data_l;
                r_out = ~r_data_l;
                if (w_tmr_tc) begin
                    w_next_state = ST_HOLD;
                    w_tmr_load   = 1'b1;
                end
            end
            ST_HOLD: begin
                w_next_state = ST_VERIFY;
                w_tmr_load   = 1'b1;
            end
            ST_VERIFY: begin
                w_next_state = ST_DONE;
                w_tmr_load   = 1'b1;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_next_state = ST_IDLE;
                w_tmr_load   = 1'b1;
            end
            default: begin
                busy         = 1'b0;
                w_next_state = ST_IDLE;
                w_tmr_load   = 1'b1;
            end
        endcase
    end

    // Write word capture and readback result; results hold until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_l   <= '0;
            r_error    <= 1'b0;
            r_err_mask <= '0;
        end else if (w_accept) begin
            r_data_l   <= data;
            r_error    <= 1'b0;
            r_err_mask <= '0;
        end else if (r_state == ST_VERIFY) begin
            r_error    <= |w_mismatch;
            r_err_mask <= w_mismatch;
        end
    end

    assign error    = r_error;
    assign err_mask = r_err_mask;

endmodule

// File: tb/tb_sr_write_sequencer.sv
// Directed bench for sr_write_sequencer. A behavioural latch-bank model feeds
// q_in; each scenario task drives stimulus on the falling edge and compares
// outputs there against hand-computed per-cycle expectations. A second
// instance runs with stretched clear/set phases.
module tb_sr_write_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Default-parameter instance.
    logic       rst, start;
    logic [7:0] data, q_in, s_out, r_out, err_mask;
    logic       is0_out, busy, done, error;
    logic [7:0] model_q  = 8'h00;
    logic [7:0] stuck0   = 8'h00;
    logic [7:0] stuck1   = 8'h00;

    // Long-phase instance.
    logic       start2;
    logic [7:0] data2, q_in2, s_out2, r_out2, err_mask2;
    logic       is0_out2, busy2, done2, error2;
    logic [7:0] model2_q = 8'h00;

    sr_write_sequencer #(.N(8), .CLR_CYCLES(1), .PULSE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .data(data), .q_in(q_in),
        .s_out(s_out), .r_out(r_out), .is0_out(is0_out), .busy(busy),
        .done(done), .error(error), .err_mask(err_mask)
    );

    sr_write_sequencer #(.N(8), .CLR_CYCLES(3), .PULSE_CYCLES(4)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .data(data2), .q_in(q_in2),
        .s_out(s_out2), .r_out(r_out2), .is0_out(is0_out2), .busy(busy2),
        .done(done2), .error(error2), .err_mask(err_mask2)
    );

    // Latch-bank model: is0 forces zero, s sets, r resets, otherwise hold.
    always @(posedge clk) begin
        if (is0_out) model_q <= 8'h00;
        else         model_q <= (model_q | s_out) & ~r_out;
        if (is0_out2) model2_q <= 8'h00;
        else          model2_q <= (model2_q | s_out2) & ~r_out2;
    end
    assign q_in  = (model_q & ~stuck0) | stuck1;
    assign q_in2 = model2_q;

    // Drive-exclusivity invariants on both instances, every cycle.
    always @(negedge clk) begin
        n_checks++;
        if (((s_out & r_out) !== 8'h00) || (is0_out && (|s_out))) begin
            n_fail++;
            $display("FAIL invariant dut: s_out=%h r_out=%h is0_out=%b", s_out, r_out, is0_out);
        end
        n_checks++;
        if (((s_out2 & r_out2) !== 8'h00) || (is0_out2 && (|s_out2))) begin
            n_fail++;
            $display("FAIL invariant dut2: s_out=%h r_out=%h is0_out=%b", s_out2, r_out2, is0_out2);
        end
    end

    // Full-write sequence on the default instance. k counts falling edges after
    // the accepting edge E0: k=0 CLEAR, 1..2 SET, 3 HOLD, 4 VERIFY, 5 DONE, 6 IDLE.
    task automatic run_write(input string tag, input logic [7:0] d,
                             input logic exp_err, input logic [7:0] exp_mask,
                             input bit repulse);
        logic       e_is0, e_done, e_busy;
        logic [7:0] e_s, e_r;
        @(negedge clk);
        data  = d;
        start = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            start = 1'b0;
            data  = 8'h00;
            if (repulse && k == 1) begin
                start = 1'b1;
                data  = 8'hFF;
            end
            e_is0  = (k == 0);
            e_s    = (k == 1 || k == 2) ? d : 8'h00;
            e_r    = (k == 1 || k == 2) ? ~d : 8'h00;
            e_done = (k == 5);
            e_busy = (k <= 5);
            n_checks++;
            if (is0_out !== e_is0) begin
                n_fail++; $display("FAIL %s is0_out k=%0d: got %b want %b", tag, k, is0_out, e_is0);
            end
            n_checks++;
            if (s_out !== e_s) begin
                n_fail++; $display("FAIL %s s_out k=%0d: got %h want %h", tag, k, s_out, e_s);
            end
            n_checks++;
            if (r_out !== e_r) begin
                n_fail++; $display("FAIL %s r_out k=%0d: got %h want %h", tag, k, r_out, e_r);
            end
            n_checks++;
            if (done !== e_done) begin
                n_fail++; $display("FAIL %s done k=%0d: got %b want %b", tag, k, done, e_done);
            end
            n_checks++;
            if (busy !== e_busy) begin
                n_fail++; $display("FAIL %s busy k=%0d: got %b want %b", tag, k, busy, e_busy);
            end
            if (k == 0) begin
                n_checks++;
                if (error !== 1'b0 || err_mask !== 8'h00) begin
                    n_fail++; $display("FAIL %s result cleared on accept: got %b/%h want 0/00", tag, error, err_mask);
                end
            end
        end
        n_checks++;
        if (error !== exp_err) begin
            n_fail++; $display("FAIL %s error: got %b want %b", tag, error, exp_err);
        end
        n_checks++;
        if (err_mask !== exp_mask) begin
            n_fail++; $display("FAIL %s err_mask: got %h want %h", tag, err_mask, exp_mask);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; data = 8'h00; start2 = 1'b0; data2 = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({s_out, r_out, is0_out, busy, done, error, err_mask} !== 28'h0) begin
                n_fail++;
                $display("FAIL reset idle cyc=%0d: s=%h r=%h is0=%b busy=%b done=%b err=%b mask=%h want all 0",
                         i, s_out, r_out, is0_out, busy, done, error, err_mask);
            end
        end
    endtask

    task automatic test_write_ok();
        run_write("write_a5", 8'hA5, 1'b0, 8'h00, 1'b0);
        n_checks++;
        if (model_q !== 8'hA5) begin
            n_fail++; $display("FAIL write_a5 bank contents: got %h want a5", model_q);
        end
    endtask

    // Bit 3 of A5 is 0, so the faulty cell is modelled stuck at 1 to make it visible.
    task automatic test_stuck_bit();
        stuck1 = 8'h08;
        run_write("stuck_b3", 8'hA5, 1'b1, 8'h08, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (error !== 1'b1 || err_mask !== 8'h08 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL stuck_hold cyc=%0d: err=%b mask=%h done=%b want 1/08/0", i, error, err_mask, done);
            end
        end
        stuck1 = 8'h00;
        run_write("after_stuck", 8'h3C, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_ignore_start();
        run_write("ignore_start", 8'hA5, 1'b0, 8'h00, 1'b1);
        n_checks++;
        if (model_q !== 8'hA5) begin
            n_fail++; $display("FAIL ignore_start bank contents: got %h want a5", model_q);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL ignore_start no_second_write cyc=%0d: done=%b busy=%b want 0/0", i, done, busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        data = 8'hA5; start = 1'b1;
        @(negedge clk);                 // CLEAR
        start = 1'b0;
        @(negedge clk);                 // first SET cycle; rst seen at E0+2
        n_checks++;
        if (s_out !== 8'hA5) begin
            n_fail++; $display("FAIL reset_mid in SET: s_out got %h want a5", s_out);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({s_out, r_out, is0_out, busy, done, error, err_mask} !== 28'h0) begin
            n_fail++;
            $display("FAIL reset_mid outputs: s=%h r=%h is0=%b busy=%b done=%b err=%b mask=%h want all 0",
                     s_out, r_out, is0_out, busy, done, error, err_mask);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL reset_mid no_done cyc=%0d: done=%b busy=%b want 0/0", i, done, busy);
            end
        end
        run_write("after_reset", 8'h3C, 1'b0, 8'h00, 1'b0);
    endtask

    // CLR_CYCLES=3, PULSE_CYCLES=4: k=0..2 CLEAR, 3..6 SET, 7 HOLD, 8 VERIFY, 9 DONE.
    task automatic test_long_phases();
        logic       e_is0, e_done, e_busy;
        logic [7:0] e_s;
        int         is0_cnt = 0;
        int         s_cnt   = 0;
        @(negedge clk);
        data2 = 8'h5A; start2 = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            start2 = 1'b0;
            data2  = 8'hC3;
            e_is0  = (k <= 2);
            e_s    = (k >= 3 && k <= 6) ? 8'h5A : 8'h00;
            e_done = (k == 9);
            e_busy = (k <= 9);
            if (is0_out2) is0_cnt++;
            if (s_out2 != 8'h00) s_cnt++;
            n_checks++;
            if (is0_out2 !== e_is0 || s_out2 !== e_s || done2 !== e_done || busy2 !== e_busy) begin
                n_fail++;
                $display("FAIL long_phases k=%0d: is0=%b s=%h done=%b busy=%b want %b/%h/%b/%b",
                         k, is0_out2, s_out2, done2, busy2, e_is0, e_s, e_done, e_busy);
            end
        end
        n_checks++;
        if (is0_cnt != 3 || s_cnt != 4) begin
            n_fail++; $display("FAIL long_phases widths: is0 %0d s %0d cycles, want 3 and 4", is0_cnt, s_cnt);
        end
        n_checks++;
        if (error2 !== 1'b0 || err_mask2 !== 8'h00 || model2_q !== 8'h5A) begin
            n_fail++; $display("FAIL long_phases result: err=%b mask=%h bank=%h want 0/00/5a", error2, err_mask2, model2_q);
        end
    endtask

    initial begin
        test_reset();
        test_write_ok();
        test_stuck_bit();
        test_ignore_start();
        test_reset_mid();
        test_long_phases();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
